// File: rtl/uio_bus_arbiter.sv
// Round-robin owner selection for the shared 8-bit uio pad bus, with an optional
// hold timeout and tri-stated turnaround cycles between consecutive owners.
module uio_bus_arbiter #(
    parameter int NREQ       = 4,
    parameter int TIMEOUT    = 255,
    parameter int TURNAROUND = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_dout,
    input  logic [NREQ*8-1:0] req_doe,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic              busy,
    output logic              timeout_pulse
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = (TIMEOUT > 0) ? HCW'(TIMEOUT - 1) : '0;
    localparam logic [HCW-1:0] HOLD_MAX  = '1;
    localparam logic [3:0]     TURN_LAST = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;
    localparam logic [IW-1:0]  LAST_IDX  = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t          state, state_n;
    logic [NREQ-1:0] gnt_n;
    logic [NREQ-1:0] mask, mask_n;
    logic [NREQ-1:0] elig;
    logic [IW-1:0]   ptr, ptr_n;
    logic [IW-1:0]   owner, owner_n;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   idx;
    logic            found;
    logic [HCW-1:0]  hold_cnt, hold_cnt_n;
    logic [3:0]      turn_cnt, turn_cnt_n;
    logic            pulse_n;
    logic            owner_req;
    logic            timeout_hit;
    logic [7:0]      doe_mux;

    assign elig      = req & ~mask;
    assign owner_req = |(req & gnt);
    assign busy      = (state != IDLE);

    // First eligible requester scanning upward from ptr, wrapping at NREQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        ptr_n       = ptr;
        owner_n     = owner;
        hold_cnt_n  = hold_cnt;
        turn_cnt_n  = turn_cnt;
        mask_n      = mask & req;
        pulse_n     = 1'b0;
        timeout_hit = 1'b0;

        if (!ena) begin
            state_n    = IDLE;
            gnt_n      = '0;
            hold_cnt_n = '0;
            turn_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state_n        = GRANT;
                        gnt_n          = '0;
                        gnt_n[winner]  = 1'b1;
                        owner_n        = winner;
                        hold_cnt_n     = '0;
                    end
                end
                GRANT: begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt_n = hold_cnt + HCW'(1);
                    end
                    timeout_hit = (TIMEOUT != 0) && (hold_cnt == HOLD_LAST);
                    // A request dropping on the timeout cycle wins: normal release.
                    if (!owner_req || timeout_hit) begin
                        gnt_n      = '0;
                        ptr_n      = (owner == LAST_IDX) ? '0 : owner + IW'(1);
                        turn_cnt_n = '0;
                        state_n    = (TURNAROUND == 0) ? IDLE : TURN;
                        if (owner_req) begin
                            mask_n[owner] = 1'b1;
                            pulse_n       = 1'b1;
                        end
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        state_n    = IDLE;
                        turn_cnt_n = '0;
                    end else begin
                        turn_cnt_n = turn_cnt + 4'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    gnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            gnt           <= '0;
            ptr           <= '0;
            owner         <= '0;
            hold_cnt      <= '0;
            turn_cnt      <= '0;
            mask          <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            gnt           <= gnt_n;
            ptr           <= ptr_n;
            owner         <= owner_n;
            hold_cnt      <= hold_cnt_n;
            turn_cnt      <= turn_cnt_n;
            mask          <= mask_n;
            timeout_pulse <= pulse_n;
        end
    end

    // AND-OR pad mux straight off the registered one-hot grant.
    always_comb begin
        uio_out = '0;
        doe_mux = '0;
        for (int i = 0; i < NREQ; i++) begin
            uio_out = uio_out | (req_dout[8*i +: 8] & {8{gnt[i]}});
            doe_mux = doe_mux | (req_doe[8*i +: 8] & {8{gnt[i]}});
        end
    end

    assign uio_oe = ena ? doe_mux : 8'h00;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scenario bench for uio_bus_arbiter (NREQ=4, TIMEOUT=8, TURNAROUND=1): each task
// queues its expected grants and checks them as the arbiter produces them.
module tb_uio_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req;
    logic [31:0] req_dout;
    logic [31:0] req_doe;
    logic [3:0]  gnt;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic        busy;
    logic        timeout_pulse;

    typedef struct {
        logic [3:0] gnt;
        logic       pulse;
    } exp_t;

    exp_t exp_q[$];
    int   exp_owner[$];
    int   total = 0;
    int   bad   = 0;

    uio_bus_arbiter #(
        .NREQ(4),
        .TIMEOUT(8),
        .TURNAROUND(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .req(req),
        .req_dout(req_dout),
        .req_doe(req_doe),
        .gnt(gnt),
        .uio_out(uio_out),
        .uio_oe(uio_oe),
        .busy(busy),
        .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        ena   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt got=%b want=0000", gnt); end
        total++; if (uio_oe !== 8'h00) begin bad++; $display("[TB] FAIL reset_oe got=%h want=00", uio_oe); end
        total++; if (uio_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_out got=%h want=00", uio_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (timeout_pulse !== 1'b0) begin bad++; $display("[TB] FAIL reset_pulse got=%b want=0", timeout_pulse); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req_dout[15:8] = 8'hA5;
        req_doe[15:8]  = 8'hFF;
        req = 4'b0010;
        @(negedge clk);
        total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL single_gnt got=%b want=0010", gnt); end
        total++; if (uio_out !== 8'hA5) begin bad++; $display("[TB] FAIL single_out got=%h want=a5", uio_out); end
        total++; if (uio_oe !== 8'hFF) begin bad++; $display("[TB] FAIL single_oe got=%h want=ff", uio_oe); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_grant got=%b want=1", busy); end
        req = 4'b0000;
        @(negedge clk);
        total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL single_release got=%b want=0000", gnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_turn got=%b want=1", busy); end
        total++; if (uio_oe !== 8'h00) begin bad++; $display("[TB] FAIL single_turn_oe got=%h want=00", uio_oe); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_idle_busy got=%b want=0", busy); end
        total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL single_idle_gnt got=%b want=0000", gnt); end
    endtask

    task automatic test_round_robin();
        int         held;
        int         gap;
        int         seen;
        int         want;
        logic [3:0] prev;
        do_reset();
        req_dout = 32'h44332211;
        req_doe  = 32'hFFFFFFFF;
        exp_owner.delete();
        for (int i = 0; i < 5; i++) exp_owner.push_back(i % 4);
        req  = 4'b1111;
        held = 0;
        gap  = 0;
        seen = 0;
        prev = 4'b0000;
        for (int cyc = 0; cyc < 200 && seen < 5; cyc++) begin
            @(negedge clk);
            if (gnt === 4'b0000) begin
                gap++;
                total++; if (uio_oe !== 8'h00) begin bad++; $display("[TB] FAIL rr_gap_oe got=%h want=00", uio_oe); end
                req = 4'b1111;
            end else begin
                if (gnt !== prev) begin
                    want = exp_owner.pop_front();
                    total++; if (gnt !== 4'(1 << want)) begin bad++; $display("[TB] FAIL rr_order got=%b want=%b", gnt, 4'(1 << want)); end
                    if (seen > 0) begin
                        total++; if (gap != 2) begin bad++; $display("[TB] FAIL rr_gap got=%0d want=2", gap); end
                    end
                    seen++;
                    held = 0;
                    gap  = 0;
                end
                held++;
                if (held == 3) req = req & ~gnt;
            end
            prev = gnt;
        end
        total++; if (seen != 5) begin bad++; $display("[TB] FAIL rr_grants got=%0d want=5", seen); end
        req = 4'b0000;
    endtask

    task automatic test_timeout();
        exp_t e;
        do_reset();
        exp_q.delete();
        req = 4'b1100;
        for (int k = 1; k <= 22; k++) begin
            e.gnt   = (k <= 8) ? 4'b0100 :
                      (k >= 11 && k <= 13) ? 4'b1000 :
                      (k == 22) ? 4'b0100 : 4'b0000;
            e.pulse = (k == 9);
            exp_q.push_back(e);
        end
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++; if (gnt !== e.gnt) begin bad++; $display("[TB] FAIL timeout_gnt cycle=%0d got=%b want=%b", k, gnt, e.gnt); end
            total++; if (timeout_pulse !== e.pulse) begin bad++; $display("[TB] FAIL timeout_pulse cycle=%0d got=%b want=%b", k, timeout_pulse, e.pulse); end
            if (k == 13) req = 4'b0100;
            if (k == 20) req = 4'b0000;
            if (k == 21) req = 4'b0100;
        end
        req = 4'b0000;
    endtask

    task automatic test_simultaneous();
        exp_t e;
        do_reset();
        exp_q.delete();
        req = 4'b0001;
        for (int k = 1; k <= 11; k++) begin
            e.gnt   = (k <= 8 || k == 11) ? 4'b0001 : 4'b0000;
            e.pulse = 1'b0;
            exp_q.push_back(e);
        end
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++; if (gnt !== e.gnt) begin bad++; $display("[TB] FAIL simul_gnt cycle=%0d got=%b want=%b", k, gnt, e.gnt); end
            total++; if (timeout_pulse !== e.pulse) begin bad++; $display("[TB] FAIL simul_pulse cycle=%0d got=%b want=%b", k, timeout_pulse, e.pulse); end
            if (k == 8) req = 4'b0000;
            if (k == 9) req = 4'b0001;
        end
        req = 4'b0000;
    endtask

    task automatic test_ena_drop();
        do_reset();
        req_dout[15:8] = 8'h3C;
        req_doe[15:8]  = 8'hFF;
        req = 4'b1010;
        @(negedge clk);
        total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL ena_first_gnt got=%b want=0010", gnt); end
        total++; if (uio_oe !== 8'hFF) begin bad++; $display("[TB] FAIL ena_first_oe got=%h want=ff", uio_oe); end
        ena = 1'b0;
        #1;
        total++; if (uio_oe !== 8'h00) begin bad++; $display("[TB] FAIL ena_comb_oe got=%h want=00", uio_oe); end
        total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL ena_gnt_held got=%b want=0010", gnt); end
        @(negedge clk);
        total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL ena_gnt_drop got=%b want=0000", gnt); end
        total++; if (timeout_pulse !== 1'b0) begin bad++; $display("[TB] FAIL ena_pulse got=%b want=0", timeout_pulse); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ena_busy got=%b want=0", busy); end
        ena = 1'b1;
        @(negedge clk);
        total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL ena_regrant got=%b want=0010", gnt); end
        req = 4'b0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_doe[23:16] = 8'h0F;
        req = 4'b0100;
        @(negedge clk);
        total++; if (gnt !== 4'b0100) begin bad++; $display("[TB] FAIL areset_pre_gnt got=%b want=0100", gnt); end
        total++; if (uio_oe !== 8'h0F) begin bad++; $display("[TB] FAIL areset_pre_oe got=%h want=0f", uio_oe); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL areset_gnt got=%b want=0000", gnt); end
        total++; if (uio_oe !== 8'h00) begin bad++; $display("[TB] FAIL areset_oe got=%h want=00", uio_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL areset_busy got=%b want=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1000;
        @(negedge clk);
        total++; if (gnt !== 4'b1000) begin bad++; $display("[TB] FAIL areset_wrap_gnt got=%b want=1000", gnt); end
        req = 4'b0000;
    endtask

    initial begin
        rst_n    = 1'b1;
        ena      = 1'b1;
        req      = 4'b0000;
        req_dout = 32'h0;
        req_doe  = 32'h0;
        #1;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_simultaneous();
        test_ena_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule
